prirv32_idu: RTL and testbench
==============================

Name: priRV32_idu

Overview:
- RV32I + Zicsr instruction decode stage, sitting between the fetch unit and priRV32_EXU.
- Accepts a fetched instruction word and its PC over a valid/ready handshake.
- Decodes the word into a 47-bit one-hot instruction vector, extracts the immediate, and reads rs1/rs2 from the register file.
- Holds the result in a one-entry pipeline register presented to the EXU with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, value held on pc_decoded after reset.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_in  input  32  fetched instruction word.
- pc_in  input  32  PC of instr_in.
- instr_valid  input  1  fetch presents instr_in/pc_in.
- instr_ready  output  1  decode can accept this cycle.
- flush  input  1  discard held and incoming instruction (branch/trap redirect).
- rf_raddr1  output  5  register file read address 1 = instr_in[19:15] (combinational).
- rf_raddr2  output  5  register file read address 2 = instr_in[24:20] (combinational).
- rf_rdata1  input  32  combinational read data for rf_raddr1.
- rf_rdata2  input  32  combinational read data for rf_raddr2.
- dec_valid  output  1  pipeline register holds a decoded instruction.
- exu_ready  input  1  EXU accepts the held instruction.
- instrset_latched  output  47  one-hot decode, bit 46..0 = lui, auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu, lb, lh, lw, lbu, lhu, sb, sh, sw, addi, slti, sltiu, xori, ori, andi, slli, srli, srai, add, sub, sll, slt, sltu, xor, srl, sra, or, and, fence, fencei, ecall, ebreak, csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci.
- imm_decoded  output  32  immediate.
- rs1_decoded  output  32  rs1 value.
- rs2_decoded  output  32  rs2 value.
- rd_decoded  output  5  destination register.
- pc_decoded  output  32  PC of the held instruction.
- illegal_decoded  output  1  held word matched no instruction.

Behaviour:
- Reset (async, rst_n=0):
  - dec_valid=0, instrset_latched=0, imm/rs1/rs2/rd=0, illegal_decoded=0, pc_decoded=RESET_PC.
  - instr_ready follows its equation (high once dec_valid=0 and flush=0).
  - Reset mid-transfer drops the instruction; no partial state is kept.
- instr_ready = !flush && (!dec_valid || exu_ready). Combinational; no dependency on instr_valid.
- Load:
  - Occurs on the rising edge when instr_valid && instr_ready.
  - All output registers load and dec_valid<=1.
  - Latency is one cycle from accept to dec_valid.
- Hold: if dec_valid && !exu_ready, all outputs are stable.
- Drain: if dec_valid && exu_ready && !(instr_valid && instr_ready), then dec_valid<=0. Data registers keep their old values.
- Back-to-back: with exu_ready=1 and instr_valid=1 held, one instruction is accepted per cycle.
- Flush:
  - flush=1 forces dec_valid<=0 next edge, regardless of exu_ready or instr_valid.
  - instr_ready=0 during flush, so nothing is accepted.
  - flush takes priority over all events.
- Decode: exactly one instrset bit is set for a legal word; all zero if illegal.
  - Match on opcode[6:0], funct3, and funct7 for R-type and shifts (0000000, or 0100000 for sub/sra/srai).
  - slli/srli/srai with any other funct7 are illegal.
  - fence: opcode 0001111, funct3=000. fencei: funct3=001.
  - ecall: only the exact word 32'h0000_0073. ebreak: only 32'h0010_0073.
  - CSR: opcode 1110011, funct3 001/010/011/101/110/111. funct3=100 is illegal.
  - Opcode[1:0]!=11 is illegal.
- illegal_decoded=1 when no bit is set; the word still travels with dec_valid=1.
- Immediate, sign-extended from bit 31 except where noted:
  - I-type: loads, jalr, ALU-imm. Shifts use imm = {27'b0, shamt}.
  - S-type: stores. B-type: branches, bit0=0. J-type: jal, bit0=0.
  - U-type: lui/auipc, imm={instr[31:12],12'b0}.
  - CSR: imm={15'b0, instr[19:15], instr[31:20]} (zimm, csr address).
  - All others: imm=0.
- rs1/rs2 values: latched from rf_rdata1/2, forced to 0 when the corresponding address is 0.
- rd_decoded = instr_in[11:7], except 0 for branches, stores, fence, fencei, ecall, ebreak, and illegal words.
- No hazard or forwarding logic; that belongs to the EXU/writeback.

Test Plan:
- Reset, then send addi x1,x2,-1 (32'hFFF1_0093), rf_rdata1=5, exu_ready=1 -> next cycle dec_valid=1, instrset bit 28 only, imm=32'hFFFF_FFFF, rs1=5, rd=1.
- Send beq x0,x3,-4 (32'hFE30_0EE3) -> instrset bit 42 only, imm=32'hFFFF_FFFC, rs1=0 even with rf_rdata1=32'hDEAD_BEEF, rd=0.
- Stall: exu_ready=0 while holding lui x5,0x12345 (32'h1234_52B7) -> instr_ready=0, outputs stable 3 cycles. Then exu_ready=1 -> next instruction loads next edge with no bubble or loss.
- Flush with dec_valid=1 and instr_valid=1 -> instr_ready=0 that cycle, dec_valid=0 next cycle, incoming word not captured.
- Illegal words 32'h0000_0000, 32'h4000_1093 (slli bad funct7), 32'h0000_4073 (csr funct3=100) -> dec_valid=1, illegal_decoded=1, instrset=0.
- csrrwi x1,mstatus,7 (32'h3003_D0F3) -> bit 2 only, imm=32'h0000_7300; ecall 32'h0000_0073 -> bit 7, rd=0; assert rst_n mid-stall -> all outputs reset immediately.

Source files
------------

// File: rtl/prirv32_idu_if.sv
`default_nettype none
// ============================================================================
// Module      : prirv32_idu_if
// Description : Bundle of every bus signal of the priRV32 decode stage.
//               Fetch handshake (instr_in, pc_in, instr_valid, instr_ready),
//               redirect (flush), register-file read port (rf_raddr*/rf_rdata*)
//               and the decoded-instruction handshake toward the EXU
//               (dec_valid, exu_ready and the *_decoded / instrset payload).
//               slave  : decode-stage view (used by prirv32_idu).
//               master : environment view (fetch, register file, EXU).
// Revision    : 1.0 - initial release
// ============================================================================
interface prirv32_idu_if;

    // fetch side
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;

    // register file read port
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;

    // EXU side
    logic        dec_valid;
    logic        exu_ready;
    logic [46:0] instrset_latched;
    logic [31:0] imm_decoded;
    logic [31:0] rs1_decoded;
    logic [31:0] rs2_decoded;
    logic [4:0]  rd_decoded;
    logic [31:0] pc_decoded;
    logic        illegal_decoded;

    modport slave (
        input  instr_in, pc_in, instr_valid, flush,
        output instr_ready,
        output rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2,
        input  exu_ready,
        output dec_valid, instrset_latched, imm_decoded, rs1_decoded,
        output rs2_decoded, rd_decoded, pc_decoded, illegal_decoded
    );

    modport master (
        output instr_in, pc_in, instr_valid, flush,
        input  instr_ready,
        input  rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2,
        output exu_ready,
        input  dec_valid, instrset_latched, imm_decoded, rs1_decoded,
        input  rs2_decoded, rd_decoded, pc_decoded, illegal_decoded
    );

endinterface
`default_nettype wire

// File: rtl/prirv32_idu.sv
`default_nettype none
// ============================================================================
// Module      : prirv32_idu
// Description : RV32I + Zicsr decode stage. Accepts an instruction word and
//               its PC from fetch, decodes it to a 47-bit one-hot vector,
//               builds the immediate, reads rs1/rs2 and holds the result in a
//               one-entry pipeline register offered to the EXU.
// Ports       : clk_in - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - prirv32_idu_if.slave (fetch, regfile, EXU signals)
// Parameters  : RESET_PC - value of pc_decoded after reset
// Revision    : 1.0 - initial release
// ============================================================================
module prirv32_idu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic           clk_in,
    input  wire logic           rst_n,
    prirv32_idu_if.slave        bus
);

    // one-hot positions inside instrset_latched
    localparam int I_LUI    = 46, I_AUIPC  = 45, I_JAL    = 44, I_JALR   = 43;
    localparam int I_BEQ    = 42, I_BNE    = 41, I_BLT    = 40, I_BGE    = 39;
    localparam int I_BLTU   = 38, I_BGEU   = 37, I_LB     = 36, I_LH     = 35;
    localparam int I_LW     = 34, I_LBU    = 33, I_LHU    = 32, I_SB     = 31;
    localparam int I_SH     = 30, I_SW     = 29, I_ADDI   = 28, I_SLTI   = 27;
    localparam int I_SLTIU  = 26, I_XORI   = 25, I_ORI    = 24, I_ANDI   = 23;
    localparam int I_SLLI   = 22, I_SRLI   = 21, I_SRAI   = 20, I_ADD    = 19;
    localparam int I_SUB    = 18, I_SLL    = 17, I_SLT    = 16, I_SLTU   = 15;
    localparam int I_XOR    = 14, I_SRL    = 13, I_SRA    = 12, I_OR     = 11;
    localparam int I_AND    = 10, I_FENCE  = 9,  I_FENCEI = 8,  I_ECALL  = 7;
    localparam int I_EBREAK = 6,  I_CSRRW  = 5,  I_CSRRS  = 4,  I_CSRRC  = 3;
    localparam int I_CSRRWI = 2,  I_CSRRSI = 1,  I_CSRRCI = 0;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;

    // immediate format selector
    localparam logic [2:0] IMM_NONE  = 3'd0;
    localparam logic [2:0] IMM_I     = 3'd1;
    localparam logic [2:0] IMM_S     = 3'd2;
    localparam logic [2:0] IMM_B     = 3'd3;
    localparam logic [2:0] IMM_J     = 3'd4;
    localparam logic [2:0] IMM_U     = 3'd5;
    localparam logic [2:0] IMM_SHAMT = 3'd6;
    localparam logic [2:0] IMM_CSR   = 3'd7;

    // ------------------------------------------------------------------
    // field extraction
    // ------------------------------------------------------------------
    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign ins    = bus.instr_in;
    assign opcode = ins[6:0];
    assign funct3 = ins[14:12];
    assign funct7 = ins[31:25];

    assign bus.rf_raddr1 = ins[19:15];
    assign bus.rf_raddr2 = ins[24:20];

    // ------------------------------------------------------------------
    // one-hot decode; anything left all-zero is illegal. Opcodes whose
    // low two bits are not 11 fall through to the default arm.
    // ------------------------------------------------------------------
    logic [46:0] dec_set;
    logic [2:0]  imm_sel;
    logic        writes_rd;

    always_comb begin
        dec_set   = '0;
        imm_sel   = IMM_NONE;
        writes_rd = 1'b1;
        case (opcode)
            OP_LUI:   begin dec_set[I_LUI]   = 1'b1; imm_sel = IMM_U; end
            OP_AUIPC: begin dec_set[I_AUIPC] = 1'b1; imm_sel = IMM_U; end
            OP_JAL:   begin dec_set[I_JAL]   = 1'b1; imm_sel = IMM_J; end
            OP_JALR: begin
                imm_sel = IMM_I;
                if (funct3 == 3'b000) dec_set[I_JALR] = 1'b1;
            end
            OP_BRANCH: begin
                imm_sel   = IMM_B;
                writes_rd = 1'b0;
                case (funct3)
                    3'b000:  dec_set[I_BEQ]  = 1'b1;
                    3'b001:  dec_set[I_BNE]  = 1'b1;
                    3'b100:  dec_set[I_BLT]  = 1'b1;
                    3'b101:  dec_set[I_BGE]  = 1'b1;
                    3'b110:  dec_set[I_BLTU] = 1'b1;
                    3'b111:  dec_set[I_BGEU] = 1'b1;
                    default: ;
                endcase
            end
            OP_LOAD: begin
                imm_sel = IMM_I;
                case (funct3)
                    3'b000:  dec_set[I_LB]  = 1'b1;
                    3'b001:  dec_set[I_LH]  = 1'b1;
                    3'b010:  dec_set[I_LW]  = 1'b1;
                    3'b100:  dec_set[I_LBU] = 1'b1;
                    3'b101:  dec_set[I_LHU] = 1'b1;
                    default: ;
                endcase
            end
            OP_STORE: begin
                imm_sel   = IMM_S;
                writes_rd = 1'b0;
                case (funct3)
                    3'b000:  dec_set[I_SB] = 1'b1;
                    3'b001:  dec_set[I_SH] = 1'b1;
                    3'b010:  dec_set[I_SW] = 1'b1;
                    default: ;
                endcase
            end
            OP_IMM: begin
                imm_sel = IMM_I;
                case (funct3)
                    3'b000: dec_set[I_ADDI]  = 1'b1;
                    3'b010: dec_set[I_SLTI]  = 1'b1;
                    3'b011: dec_set[I_SLTIU] = 1'b1;
                    3'b100: dec_set[I_XORI]  = 1'b1;
                    3'b110: dec_set[I_ORI]   = 1'b1;
                    3'b111: dec_set[I_ANDI]  = 1'b1;
                    3'b001: begin
                        imm_sel = IMM_SHAMT;
                        if (funct7 == F7_BASE) dec_set[I_SLLI] = 1'b1;
                    end
                    3'b101: begin
                        imm_sel = IMM_SHAMT;
                        if (funct7 == F7_BASE)     dec_set[I_SRLI] = 1'b1;
                        else if (funct7 == F7_ALT) dec_set[I_SRAI] = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_REG: begin
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec_set[I_ADD]  = 1'b1;
                    {F7_ALT,  3'b000}: dec_set[I_SUB]  = 1'b1;
                    {F7_BASE, 3'b001}: dec_set[I_SLL]  = 1'b1;
                    {F7_BASE, 3'b010}: dec_set[I_SLT]  = 1'b1;
                    {F7_BASE, 3'b011}: dec_set[I_SLTU] = 1'b1;
                    {F7_BASE, 3'b100}: dec_set[I_XOR]  = 1'b1;
                    {F7_BASE, 3'b101}: dec_set[I_SRL]  = 1'b1;
                    {F7_ALT,  3'b101}: dec_set[I_SRA]  = 1'b1;
                    {F7_BASE, 3'b110}: dec_set[I_OR]   = 1'b1;
                    {F7_BASE, 3'b111}: dec_set[I_AND]  = 1'b1;
                    default: ;
                endcase
            end
            OP_FENCE: begin
                writes_rd = 1'b0;
                if (funct3 == 3'b000)      dec_set[I_FENCE]  = 1'b1;
                else if (funct3 == 3'b001) dec_set[I_FENCEI] = 1'b1;
            end
            OP_SYSTEM: begin
                imm_sel = IMM_CSR;
                case (funct3)
                    3'b000: begin
                        // only the two exact encodings are accepted
                        imm_sel   = IMM_NONE;
                        writes_rd = 1'b0;
                        if (ins == WORD_ECALL)       dec_set[I_ECALL]  = 1'b1;
                        else if (ins == WORD_EBREAK) dec_set[I_EBREAK] = 1'b1;
                    end
                    3'b001:  dec_set[I_CSRRW]  = 1'b1;
                    3'b010:  dec_set[I_CSRRS]  = 1'b1;
                    3'b011:  dec_set[I_CSRRC]  = 1'b1;
                    3'b101:  dec_set[I_CSRRWI] = 1'b1;
                    3'b110:  dec_set[I_CSRRSI] = 1'b1;
                    3'b111:  dec_set[I_CSRRCI] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // immediate, rd and operand formation
    // ------------------------------------------------------------------
    logic        dec_illegal;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rd;
    logic [31:0] dec_rs1;
    logic [31:0] dec_rs2;

    assign dec_illegal = ~|dec_set;

    always_comb begin
        dec_imm = '0;
        case (imm_sel)
            IMM_I:     dec_imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:     dec_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:     dec_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:     dec_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_U:     dec_imm = {ins[31:12], 12'b0};
            IMM_SHAMT: dec_imm = {27'b0, ins[24:20]};
            IMM_CSR:   dec_imm = {15'b0, ins[19:15], ins[31:20]};
            default:   dec_imm = '0;
        endcase
        // a rejected word carries no immediate
        if (dec_illegal) dec_imm = '0;
    end

    assign dec_rd  = (writes_rd && !dec_illegal) ? ins[11:7] : 5'd0;
    assign dec_rs1 = (ins[19:15] == 5'd0) ? 32'd0 : bus.rf_rdata1;
    assign dec_rs2 = (ins[24:20] == 5'd0) ? 32'd0 : bus.rf_rdata2;

    // ------------------------------------------------------------------
    // one-entry pipeline register
    // ------------------------------------------------------------------
    logic        held_valid;
    logic [46:0] held_set;
    logic [31:0] held_imm;
    logic [31:0] held_rs1;
    logic [31:0] held_rs2;
    logic [4:0]  held_rd;
    logic [31:0] held_pc;
    logic        held_illegal;
    logic        accept;

    // flush already blocks acceptance here, so it wins over a load
    assign bus.instr_ready = !bus.flush && (!held_valid || bus.exu_ready);
    assign accept          = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            held_valid   <= 1'b0;
            held_set     <= '0;
            held_imm     <= '0;
            held_rs1     <= '0;
            held_rs2     <= '0;
            held_rd      <= '0;
            held_pc      <= RESET_PC;
            held_illegal <= 1'b0;
        end else if (bus.flush) begin
            held_valid <= 1'b0;
        end else if (accept) begin
            held_valid   <= 1'b1;
            held_set     <= dec_set;
            held_imm     <= dec_imm;
            held_rs1     <= dec_rs1;
            held_rs2     <= dec_rs2;
            held_rd      <= dec_rd;
            held_pc      <= bus.pc_in;
            held_illegal <= dec_illegal;
        end else if (bus.exu_ready) begin
            // drained: payload is left as-is, only the valid drops
            held_valid <= 1'b0;
        end
    end

    assign bus.dec_valid        = held_valid;
    assign bus.instrset_latched = held_set;
    assign bus.imm_decoded      = held_imm;
    assign bus.rs1_decoded      = held_rs1;
    assign bus.rs2_decoded      = held_rs2;
    assign bus.rd_decoded       = held_rd;
    assign bus.pc_decoded       = held_pc;
    assign bus.illegal_decoded  = held_illegal;

endmodule
`default_nettype wire

// File: tb/tb_prirv32_idu.sv
`default_nettype none
// ============================================================================
// Module      : tb_prirv32_idu
// Description : Directed self-checking bench for prirv32_idu. Each scenario
//               task drives the interface and compares against hand-derived
//               expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prirv32_idu;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

    // decode table: word, one-hot position, immediate, rd
    localparam int NTBL = 11;
    localparam logic [31:0] T_WORD [0:NTBL-1] = '{
        32'h3003_D0F3, 32'h0000_0073, 32'h0010_0073, 32'h4030_D093,
        32'hFE20_AE23, 32'hFF80_A183, 32'h4020_81B3, 32'h0FF0_008F,
        32'h0000_100F, 32'h3410_22F3, 32'h0042_80E7};
    localparam int T_BIT [0:NTBL-1] = '{2, 7, 6, 20, 29, 34, 18, 9, 8, 4, 43};
    localparam logic [31:0] T_IMM [0:NTBL-1] = '{
        32'h0000_7300, 32'h0, 32'h0, 32'h3,
        32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0, 32'h0,
        32'h0, 32'h0000_0341, 32'h4};
    localparam logic [4:0] T_RD [0:NTBL-1] = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd0, 5'd3, 5'd3, 5'd0, 5'd0, 5'd5, 5'd1};

    localparam int NILL = 5;
    localparam logic [31:0] ILL_WORD [0:NILL-1] = '{
        32'h0000_0000, 32'h4000_1093, 32'h0000_4073, 32'h0020_0073, 32'h0000_0090};

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    prirv32_idu_if bus ();

    prirv32_idu #(.RESET_PC(TB_RESET_PC)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2);
        bus.instr_in    = w;
        bus.pc_in       = pc;
        bus.rf_rdata1   = d1;
        bus.rf_rdata2   = d2;
        bus.instr_valid = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.dec_valid); end
        n_cmp++; if (bus.instrset_latched !== 47'd0) begin n_err++; $display("FAIL rst_set: got %h want 0", bus.instrset_latched); end
        n_cmp++; if (bus.imm_decoded !== 32'd0) begin n_err++; $display("FAIL rst_imm: got %h want 0", bus.imm_decoded); end
        n_cmp++; if (bus.rd_decoded !== 5'd0) begin n_err++; $display("FAIL rst_rd: got %0d want 0", bus.rd_decoded); end
        n_cmp++; if (bus.pc_decoded !== TB_RESET_PC) begin n_err++; $display("FAIL rst_pc: got %h want %h", bus.pc_decoded, TB_RESET_PC); end
        n_cmp++; if (bus.illegal_decoded !== 1'b0) begin n_err++; $display("FAIL rst_illegal: got %b want 0", bus.illegal_decoded); end
        n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.instr_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        bus.exu_ready = 1'b1;
        drive(32'hFFF1_0093, 32'h0000_0100, 32'd5, 32'h77);
        #1;
        n_cmp++; if (bus.rf_raddr1 !== 5'd2) begin n_err++; $display("FAIL addi_raddr1: got %0d want 2", bus.rf_raddr1); end
        n_cmp++; if (bus.rf_raddr2 !== 5'd31) begin n_err++; $display("FAIL addi_raddr2: got %0d want 31", bus.rf_raddr2); end
        tick();
        n_cmp++; if (bus.dec_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %b want 1", bus.dec_valid); end
        n_cmp++; if (bus.instrset_latched !== (47'd1 << 28)) begin n_err++; $display("FAIL addi_set: got %h want %h", bus.instrset_latched, 47'd1 << 28); end
        n_cmp++; if (bus.imm_decoded !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL addi_imm: got %h want ffffffff", bus.imm_decoded); end
        n_cmp++; if (bus.rs1_decoded !== 32'd5) begin n_err++; $display("FAIL addi_rs1: got %h want 5", bus.rs1_decoded); end
        n_cmp++; if (bus.rs2_decoded !== 32'h77) begin n_err++; $display("FAIL addi_rs2: got %h want 77", bus.rs2_decoded); end
        n_cmp++; if (bus.rd_decoded !== 5'd1) begin n_err++; $display("FAIL addi_rd: got %0d want 1", bus.rd_decoded); end
        n_cmp++; if (bus.pc_decoded !== 32'h100) begin n_err++; $display("FAIL addi_pc: got %h want 100", bus.pc_decoded); end
        bus.instr_valid = 1'b0;
        tick();
        n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", bus.dec_valid); end
        n_cmp++; if (bus.imm_decoded !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL drain_imm_kept: got %h want ffffffff", bus.imm_decoded); end
    endtask

    task automatic test_beq();
        drive(32'hFE30_0EE3, 32'h0000_0104, 32'hDEAD_BEEF, 32'h1234);
        tick();
        n_cmp++; if (bus.instrset_latched !== (47'd1 << 42)) begin n_err++; $display("FAIL beq_set: got %h want %h", bus.instrset_latched, 47'd1 << 42); end
        n_cmp++; if (bus.imm_decoded !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL beq_imm: got %h want fffffffc", bus.imm_decoded); end
        n_cmp++; if (bus.rs1_decoded !== 32'd0) begin n_err++; $display("FAIL beq_rs1_x0: got %h want 0", bus.rs1_decoded); end
        n_cmp++; if (bus.rs2_decoded !== 32'h1234) begin n_err++; $display("FAIL beq_rs2: got %h want 1234", bus.rs2_decoded); end
        n_cmp++; if (bus.rd_decoded !== 5'd0) begin n_err++; $display("FAIL beq_rd: got %0d want 0", bus.rd_decoded); end
        bus.instr_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall_back_to_back();
        bus.exu_ready = 1'b0;
        drive(32'h1234_52B7, 32'h0000_0200, 32'd0, 32'd0);
        tick();
        n_cmp++; if (bus.instrset_latched !== (47'd1 << 46)) begin n_err++; $display("FAIL lui_set: got %h want %h", bus.instrset_latched, 47'd1 << 46); end
        n_cmp++; if (bus.imm_decoded !== 32'h1234_5000) begin n_err++; $display("FAIL lui_imm: got %h want 12345000", bus.imm_decoded); end
        n_cmp++; if (bus.rd_decoded !== 5'd5) begin n_err++; $display("FAIL lui_rd: got %0d want 5", bus.rd_decoded); end
        drive(32'hFFF1_0093, 32'h0000_0204, 32'd9, 32'd0);
        #1;
        n_cmp++; if (bus.instr_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b want 0", bus.instr_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (bus.dec_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", c, bus.dec_valid); end
            n_cmp++; if (bus.imm_decoded !== 32'h1234_5000) begin n_err++; $display("FAIL stall_imm[%0d]: got %h want 12345000", c, bus.imm_decoded); end
            n_cmp++; if (bus.pc_decoded !== 32'h200) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want 200", c, bus.pc_decoded); end
        end
        bus.exu_ready = 1'b1;
        #1;
        n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", bus.instr_ready); end
        tick();
        n_cmp++; if (bus.instrset_latched !== (47'd1 << 28)) begin n_err++; $display("FAIL release_set: got %h want %h", bus.instrset_latched, 47'd1 << 28); end
        n_cmp++; if (bus.pc_decoded !== 32'h204) begin n_err++; $display("FAIL release_pc: got %h want 204", bus.pc_decoded); end
        n_cmp++; if (bus.rs1_decoded !== 32'd9) begin n_err++; $display("FAIL release_rs1: got %h want 9", bus.rs1_decoded); end
        drive(32'h0000_1117, 32'h0000_0208, 32'd0, 32'd0);
        tick();
        n_cmp++; if (bus.instrset_latched !== (47'd1 << 45)) begin n_err++; $display("FAIL b2b_auipc_set: got %h want %h", bus.instrset_latched, 47'd1 << 45); end
        n_cmp++; if (bus.imm_decoded !== 32'h1000) begin n_err++; $display("FAIL b2b_auipc_imm: got %h want 1000", bus.imm_decoded); end
        n_cmp++; if (bus.rd_decoded !== 5'd2) begin n_err++; $display("FAIL b2b_auipc_rd: got %0d want 2", bus.rd_decoded); end
        drive(32'h0080_00EF, 32'h0000_020C, 32'd0, 32'd0);
        tick();
        n_cmp++; if (bus.instrset_latched !== (47'd1 << 44)) begin n_err++; $display("FAIL b2b_jal_set: got %h want %h", bus.instrset_latched, 47'd1 << 44); end
        n_cmp++; if (bus.imm_decoded !== 32'h8) begin n_err++; $display("FAIL b2b_jal_imm: got %h want 8", bus.imm_decoded); end
        n_cmp++; if (bus.dec_valid !== 1'b1) begin n_err++; $display("FAIL b2b_jal_valid: got %b want 1", bus.dec_valid); end
    endtask

    task automatic test_flush();
        bus.flush = 1'b1;
        drive(32'h0020_81B3, 32'h0000_0300, 32'd0, 32'd0);
        #1;
        n_cmp++; if (bus.instr_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", bus.instr_ready); end
        tick();
        n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", bus.dec_valid); end
        n_cmp++; if (bus.instrset_latched !== (47'd1 << 44)) begin n_err++; $display("FAIL flush_not_captured: got %h want %h", bus.instrset_latched, 47'd1 << 44); end
        n_cmp++; if (bus.pc_decoded !== 32'h20C) begin n_err++; $display("FAIL flush_pc: got %h want 20c", bus.pc_decoded); end
        bus.flush = 1'b0;
        tick();
        n_cmp++; if (bus.instrset_latched !== (47'd1 << 19)) begin n_err++; $display("FAIL post_flush_add_set: got %h want %h", bus.instrset_latched, 47'd1 << 19); end
        n_cmp++; if (bus.rd_decoded !== 5'd3) begin n_err++; $display("FAIL post_flush_add_rd: got %0d want 3", bus.rd_decoded); end
        n_cmp++; if (bus.pc_decoded !== 32'h300) begin n_err++; $display("FAIL post_flush_pc: got %h want 300", bus.pc_decoded); end
        bus.instr_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        for (int i = 0; i < NILL; i++) begin
            drive(ILL_WORD[i], 32'h0000_0400 + 32'(i * 4), 32'h11, 32'h22);
            tick();
            n_cmp++; if (bus.dec_valid !== 1'b1) begin n_err++; $display("FAIL ill_valid[%0d]: got %b want 1", i, bus.dec_valid); end
            n_cmp++; if (bus.illegal_decoded !== 1'b1) begin n_err++; $display("FAIL ill_flag[%0d]: got %b want 1", i, bus.illegal_decoded); end
            n_cmp++; if (bus.instrset_latched !== 47'd0) begin n_err++; $display("FAIL ill_set[%0d]: got %h want 0", i, bus.instrset_latched); end
            n_cmp++; if (bus.rd_decoded !== 5'd0) begin n_err++; $display("FAIL ill_rd[%0d]: got %0d want 0", i, bus.rd_decoded); end
            n_cmp++; if (bus.imm_decoded !== 32'd0) begin n_err++; $display("FAIL ill_imm[%0d]: got %h want 0", i, bus.imm_decoded); end
        end
        bus.instr_valid = 1'b0;
        tick();
    endtask

    task automatic test_decode_table();
        logic [31:0] w;
        logic [31:0] d1;
        logic [31:0] exp_rs1;
        for (int i = 0; i < NTBL; i++) begin
            w       = T_WORD[i];
            d1      = 32'hA5A5_0000 + 32'(i);
            exp_rs1 = (w[19:15] == 5'd0) ? 32'd0 : d1;
            drive(w, 32'h0000_0500 + 32'(i * 4), d1, 32'h0);
            tick();
            n_cmp++; if (bus.instrset_latched !== (47'd1 << T_BIT[i])) begin n_err++; $display("FAIL tbl_set[%0d]: got %h want %h", i, bus.instrset_latched, 47'd1 << T_BIT[i]); end
            n_cmp++; if (bus.illegal_decoded !== 1'b0) begin n_err++; $display("FAIL tbl_illegal[%0d]: got %b want 0", i, bus.illegal_decoded); end
            n_cmp++; if (bus.imm_decoded !== T_IMM[i]) begin n_err++; $display("FAIL tbl_imm[%0d]: got %h want %h", i, bus.imm_decoded, T_IMM[i]); end
            n_cmp++; if (bus.rd_decoded !== T_RD[i]) begin n_err++; $display("FAIL tbl_rd[%0d]: got %0d want %0d", i, bus.rd_decoded, T_RD[i]); end
            n_cmp++; if (bus.rs1_decoded !== exp_rs1) begin n_err++; $display("FAIL tbl_rs1[%0d]: got %h want %h", i, bus.rs1_decoded, exp_rs1); end
        end
        bus.instr_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        bus.exu_ready = 1'b0;
        drive(32'h1234_52B7, 32'h0000_0600, 32'h5, 32'h66);
        tick();
        n_cmp++; if (bus.dec_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", bus.dec_valid); end
        n_cmp++; if (bus.rs2_decoded !== 32'h66) begin n_err++; $display("FAIL mid_pre_rs2: got %h want 66", bus.rs2_decoded); end
        bus.instr_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", bus.dec_valid); end
        n_cmp++; if (bus.instrset_latched !== 47'd0) begin n_err++; $display("FAIL mid_rst_set: got %h want 0", bus.instrset_latched); end
        n_cmp++; if (bus.imm_decoded !== 32'd0) begin n_err++; $display("FAIL mid_rst_imm: got %h want 0", bus.imm_decoded); end
        n_cmp++; if (bus.rs2_decoded !== 32'd0) begin n_err++; $display("FAIL mid_rst_rs2: got %h want 0", bus.rs2_decoded); end
        n_cmp++; if (bus.rd_decoded !== 5'd0) begin n_err++; $display("FAIL mid_rst_rd: got %0d want 0", bus.rd_decoded); end
        n_cmp++; if (bus.pc_decoded !== TB_RESET_PC) begin n_err++; $display("FAIL mid_rst_pc: got %h want %h", bus.pc_decoded, TB_RESET_PC); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.instr_in    = 32'd0;
        bus.pc_in       = 32'd0;
        bus.instr_valid = 1'b0;
        bus.flush       = 1'b0;
        bus.rf_rdata1   = 32'd0;
        bus.rf_rdata2   = 32'd0;
        bus.exu_ready   = 1'b0;
        test_reset();
        test_addi();
        test_beq();
        test_stall_back_to_back();
        test_flush();
        test_illegal();
        test_decode_table();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
